// File: rtl/dah_tile_sched.sv
// dA*h_prev tile scheduler: streams N_TILES state-buffer tiles through the FP16
// multiplier array and returns the products in issue order via a credit-guarded FIFO.

module dah_tile_sched_chk #(
  parameter int CW = 4
) (
  input logic          clk,
  input logic          rstn,
  input logic          push_i,
  input logic          pop_i,
  input logic          full_i
);
  // A product arriving into a full FIFO with no same-cycle pop would be lost.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push_i && full_i && !pop_i));
endmodule

module dah_tile_sched #(
  parameter int DW         = 16,
  parameter int N_TILE     = 16,
  parameter int N_TILES    = 8,
  parameter int MUL_LAT    = 6,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 8,
  parameter int TW         = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [DW-1:0]        dA_i,
  input  logic [AW-1:0]        base_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 hbuf_ren_o,
  output logic [AW-1:0]        hbuf_raddr_o,
  input  logic [N_TILE*DW-1:0] hbuf_rdata_i,
  output logic                 mul_valid_o,
  output logic [DW-1:0]        mul_dA_o,
  output logic [N_TILE*DW-1:0] mul_hprev_o,
  input  logic                 mul_valid_i,
  input  logic [N_TILE*DW-1:0] mul_dAh_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [N_TILE*DW-1:0] out_data_o,
  output logic [TW-1:0]        out_tidx_o,
  output logic                 out_last_o
);
  localparam int TDW = N_TILE * DW;
  localparam int EW  = TDW + TW;
  localparam int FL  = RD_LAT + MUL_LAT;
  localparam int FCW = $clog2(FL + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_FLUSH = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [TW-1:0]  LAST_T    = TW'(N_TILES - 1);
  localparam logic [FCW-1:0] FLUSH_END = FCW'(FL - 1);
  localparam logic [CW:0]    DEPTH_C   = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]  FULL_C    = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]  PTR_END   = PW'(FIFO_DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [FCW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [DW-1:0]     dA_q, dA_d;
  logic [AW-1:0]     base_q, base_d;
  logic [TW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [TW-1:0]     wr_tidx_q, wr_tidx_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [RD_LAT-1:0] ren_pipe_q, ren_pipe_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic [EW-1:0]     fifo_mem_q [FIFO_DEPTH];

  logic              out_valid_s, pop_s, issue_s, capture_s, spurious_s, credit_ok_s, fifo_full_s;
  logic [CW:0]       credit_use_s;
  logic [EW-1:0]     head_s;
  logic [TW-1:0]     head_tidx_s;

  // Handshake, credit and result-capture decode.
  always_comb begin
    out_valid_s  = (fifo_cnt_q != '0);
    pop_s        = out_valid_s & out_ready_i;
    fifo_full_s  = (fifo_cnt_q == FULL_C);
    head_s       = fifo_mem_q[rd_ptr_q];
    head_tidx_s  = head_s[TW-1:0];
    // Same-cycle pop frees a credit so issue resumes the cycle ready returns.
    credit_use_s = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    credit_ok_s  = (credit_use_s < (DEPTH_C + {{CW{1'b0}}, pop_s}));
    issue_s      = (state_q == ST_RUN) & credit_ok_s;
    capture_s    = mul_valid_i & (state_q != ST_FLUSH) & (inflight_q != '0);
    spurious_s   = mul_valid_i & (state_q != ST_FLUSH) & (inflight_q == '0);
  end

  // Command sequencing.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    dA_d        = dA_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    wr_tidx_d   = capture_s ? (wr_tidx_q + TW'(1)) : wr_tidx_q;
    done_d      = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_END) begin
          state_d     = ST_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FCW'(1);
        end
      end
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_RUN;
          dA_d        = dA_i;
          base_d      = base_i;
          issue_cnt_d = '0;
          wr_tidx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s) begin
          issue_cnt_d = issue_cnt_q + TW'(1);
          state_d     = (issue_cnt_q == LAST_T) ? ST_DRAIN : ST_RUN;
        end else begin
          issue_cnt_d = issue_cnt_q;
        end
      end
      ST_DRAIN: begin
        if (pop_s && (head_tidx_s == LAST_T)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_FLUSH;
      end
    endcase
  end

  // In-flight accounting, FIFO pointers, read-enable delay line and sticky error.
  always_comb begin
    if (issue_s && !capture_s) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!issue_s && capture_s) begin
      inflight_d = inflight_q - CW'(1);
    end else begin
      inflight_d = inflight_q;
    end
    if (capture_s && !pop_s) begin
      fifo_cnt_d = fifo_cnt_q + CW'(1);
    end else if (!capture_s && pop_s) begin
      fifo_cnt_d = fifo_cnt_q - CW'(1);
    end else begin
      fifo_cnt_d = fifo_cnt_q;
    end
    wr_ptr_d   = capture_s ? ((wr_ptr_q == PTR_END) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop_s ? ((rd_ptr_q == PTR_END) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
    ren_pipe_d = (ren_pipe_q << 1) | RD_LAT'(issue_s);
    err_d      = err_q | spurious_s;
  end

  // Control and counter state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      dA_q        <= '0;
      base_q      <= '0;
      issue_cnt_q <= '0;
      wr_tidx_q   <= '0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ren_pipe_q  <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      dA_q        <= dA_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      wr_tidx_q   <= wr_tidx_d;
      inflight_q  <= inflight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ren_pipe_q  <= ren_pipe_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  // Result storage; entries are only observed while counted valid, so no reset.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      fifo_mem_q[wr_ptr_q] <= {mul_dAh_i, wr_tidx_q};
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign hbuf_ren_o   = issue_s;
  assign hbuf_raddr_o = base_q + AW'(issue_cnt_q);
  assign mul_valid_o  = ren_pipe_q[RD_LAT-1];
  assign mul_dA_o     = dA_q;
  assign mul_hprev_o  = hbuf_rdata_i;
  assign out_valid_o  = out_valid_s;
  assign out_data_o   = out_valid_s ? head_s[EW-1:TW] : '0;
  assign out_tidx_o   = out_valid_s ? head_tidx_s : '0;
  assign out_last_o   = out_valid_s & (head_tidx_s == LAST_T);

  dah_tile_sched_chk #(.CW(CW)) u_chk (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (capture_s),
    .pop_i  (pop_s),
    .full_i (fifo_full_s)
  );
endmodule

// File: tb/tb_dah_tile_sched.sv
// Self-checking bench for dah_tile_sched with state-buffer and multiplier-array
// models and a tile-level reference of the expected address/result streams.
`timescale 1ns/1ps
module tb_dah_tile_sched;
  localparam int DW = 16, N_TILE = 16, N_TILES = 8, MUL_LAT = 6, RD_LAT = 1;
  localparam int FIFO_DEPTH = 8, AW = 8, TW = 3;
  localparam int TD = N_TILE * DW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_i = 1'b0;
  logic [DW-1:0] dA_i = '0;
  logic [AW-1:0] base_i = '0;
  logic          busy_o, done_o, err_o, hbuf_ren_o;
  logic [AW-1:0] hbuf_raddr_o;
  logic [TD-1:0] hbuf_rdata_i;
  logic          mul_valid_o;
  logic [DW-1:0] mul_dA_o;
  logic [TD-1:0] mul_hprev_o;
  logic          mul_valid_i;
  logic [TD-1:0] mul_dAh_i;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [TD-1:0] out_data_o;
  logic [TW-1:0] out_tidx_o;
  logic          out_last_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dah_tile_sched #(
    .DW(DW), .N_TILE(N_TILE), .N_TILES(N_TILES), .MUL_LAT(MUL_LAT),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .AW(AW), .TW(TW)
  ) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .dA_i(dA_i), .base_i(base_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .hbuf_ren_o(hbuf_ren_o), .hbuf_raddr_o(hbuf_raddr_o), .hbuf_rdata_i(hbuf_rdata_i),
    .mul_valid_o(mul_valid_o), .mul_dA_o(mul_dA_o), .mul_hprev_o(mul_hprev_o),
    .mul_valid_i(mul_valid_i), .mul_dAh_i(mul_dAh_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_tidx_o(out_tidx_o), .out_last_o(out_last_o)
  );

  // Truncating FP16 multiply for normal operands (the array under test is external).
  function automatic logic [15:0] fp16_mul(logic [15:0] a, logic [15:0] b);
    logic [21:0] m;
    int e;
    logic [9:0] f;
    m = {1'b1, a[9:0]} * {1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (m[21]) begin e = e + 1; f = m[20:11]; end
    else f = m[19:10];
    return {a[15] ^ b[15], 5'(e), f};
  endfunction

  function automatic logic [TD-1:0] tile_mul(logic [DW-1:0] a, logic [TD-1:0] h);
    logic [TD-1:0] r;
    for (int l = 0; l < N_TILE; l++) r[l*DW +: DW] = fp16_mul(a, h[l*DW +: DW]);
    return r;
  endfunction

  function automatic logic [15:0] rand_fp16(int lo, int hi);
    return {1'($urandom % 2), 5'($urandom_range(hi, lo)), 10'($urandom % 1024)};
  endfunction

  // State buffer and multiplier array models.
  logic [TD-1:0] hmem [256];
  logic [TD-1:0] rdata_r = '0;
  logic [MUL_LAT-1:0] pv = '0;
  logic [TD-1:0] pd [MUL_LAT];
  logic inj = 1'b0;

  always @(posedge clk) if (hbuf_ren_o) rdata_r <= hmem[hbuf_raddr_o];
  assign hbuf_rdata_i = rdata_r;

  always @(posedge clk) begin
    pv <= {pv[MUL_LAT-2:0], mul_valid_o};
    pd[0] <= tile_mul(mul_dA_o, mul_hprev_o);
    for (int i = 1; i < MUL_LAT; i++) pd[i] <= pd[i-1];
  end
  assign mul_valid_i = pv[MUL_LAT-1] | inj;
  assign mul_dAh_i   = pd[MUL_LAT-1];

  // Observation of reads, pops, done pulses and output stability under stall.
  int ren_cyc[$];
  logic [AW-1:0] ren_addr[$];
  int pop_cyc[$];
  logic [TD-1:0] pop_data[$];
  logic [TW-1:0] pop_tidx[$];
  logic pop_last[$];
  int done_cyc[$];
  logic done_busy[$];
  int stab_bad = 0;
  logic hold_r = 1'b0;
  logic [TD-1:0] hold_data;
  logic [TW-1:0] hold_tidx;
  logic hold_last;

  always @(negedge clk) begin
    if (rstn) begin
      if (hbuf_ren_o) begin ren_cyc.push_back(cyc); ren_addr.push_back(hbuf_raddr_o); end
      if (out_valid_o && out_ready_i) begin
        pop_cyc.push_back(cyc); pop_data.push_back(out_data_o);
        pop_tidx.push_back(out_tidx_o); pop_last.push_back(out_last_o);
      end
      if (done_o) begin done_cyc.push_back(cyc); done_busy.push_back(busy_o); end
      if (hold_r && (!out_valid_o || out_data_o !== hold_data || out_tidx_o !== hold_tidx ||
                     out_last_o !== hold_last)) stab_bad++;
      hold_r = out_valid_o && !out_ready_i;
      hold_data = out_data_o; hold_tidx = out_tidx_o; hold_last = out_last_o;
    end else begin
      hold_r = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon;
    ren_cyc.delete(); ren_addr.delete(); pop_cyc.delete(); pop_data.delete();
    pop_tidx.delete(); pop_last.delete(); done_cyc.delete(); done_busy.delete();
    stab_bad = 0;
  endtask

  task automatic fill_random(logic [AW-1:0] base);
    logic [TD-1:0] t;
    for (int k = 0; k < N_TILES; k++) begin
      for (int l = 0; l < N_TILE; l++) t[l*DW +: DW] = rand_fp16(10, 20);
      hmem[AW'(base + AW'(k))] = t;
    end
  endtask

  task automatic issue_start(logic [DW-1:0] a, logic [AW-1:0] b);
    dA_i = a; base_i = b; start_i = 1'b1; t0 = cyc;
    tick;
    start_i = 1'b0;
  endtask

  task automatic wait_done(int want, int bound);
    int n = 0;
    while (done_cyc.size() < want && n < bound) begin tick; n++; end
  endtask

  task automatic test_reset;
    int n;
    clear_mon;
    rstn = 1'b0;
    repeat (3) tick;
    checks++;
    if (busy_o !== 1'b1 || hbuf_ren_o !== 1'b0 || hbuf_raddr_o !== '0 || mul_valid_o !== 1'b0 ||
        mul_dA_o !== '0 || out_valid_o !== 1'b0 || out_data_o !== '0 || out_tidx_o !== '0 ||
        out_last_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b ren=%0b mvalid=%0b ovalid=%0b done=%0b err=%0b required busy=1 others 0",
               busy_o, hbuf_ren_o, mul_valid_o, out_valid_o, done_o, err_o);
    end
    rstn = 1'b1;
    n = 0;
    while (busy_o && n < 20) begin
      n++;
      inj = (n == 3);
      start_i = (n == 2);
      tick;
    end
    inj = 1'b0; start_i = 1'b0;
    checks++;
    if (n !== 7) begin failures++; $display("FAIL flush_len: busy for %0d cycles, required 7", n); end
    tick;
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b0 || ren_cyc.size() !== 0) begin
      failures++;
      $display("FAIL flush_drop: err=%0b busy=%0b rens=%0d required 0 0 0", err_o, busy_o, ren_cyc.size());
    end
  endtask

  task automatic test_single;
    logic [TD-1:0] exp_t;
    exp_t = {N_TILE{16'h4000}};
    for (int k = 0; k < N_TILES; k++) hmem[8'h10 + k] = {N_TILE{16'h3C00}};
    out_ready_i = 1'b1;
    clear_mon;
    issue_start(16'h4000, 8'h10);
    wait_done(1, 60);
    checks++;
    if (ren_cyc.size() !== N_TILES) begin failures++; $display("FAIL single_rencount: got %0d required %0d", ren_cyc.size(), N_TILES); end
    for (int k = 0; k < N_TILES && k < ren_cyc.size(); k++) begin
      checks++;
      if (ren_addr[k] !== AW'(8'h10 + k) || ren_cyc[k] - t0 !== k + 1) begin
        failures++;
        $display("FAIL single_ren%0d: addr=%0h cycle=%0d required addr=%0h cycle=%0d", k, ren_addr[k], ren_cyc[k] - t0, 8'h10 + k, k + 1);
      end
    end
    checks++;
    if (pop_data.size() !== N_TILES) begin failures++; $display("FAIL single_popcount: got %0d required %0d", pop_data.size(), N_TILES); end
    for (int k = 0; k < N_TILES && k < pop_data.size(); k++) begin
      checks++;
      if (pop_data[k] !== exp_t || pop_tidx[k] !== TW'(k) || pop_last[k] !== (k == N_TILES - 1)) begin
        failures++;
        $display("FAIL single_pop%0d: lane0=%0h tidx=%0d last=%0b required lane0=4000 tidx=%0d last=%0b",
                 k, pop_data[k][15:0], pop_tidx[k], pop_last[k], k, k == N_TILES - 1);
      end
    end
    checks++;
    if (pop_cyc.size() != N_TILES || pop_cyc[0] - t0 !== 9 || pop_cyc[N_TILES-1] - t0 !== 16) begin
      failures++; $display("FAIL single_poptiming: first/last pop cycles wrong, required 9 and 16");
    end
    checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] - t0 !== 17 || done_busy[0] !== 1'b0) begin
      failures++; $display("FAIL single_done: count=%0d required one pulse at cycle 17 with busy low", done_cyc.size());
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] a;
    logic [AW-1:0] b;
    int t1;
    a = rand_fp16(13, 17); b = AW'($urandom);
    fill_random(b);
    out_ready_i = 1'b0;
    clear_mon;
    issue_start(a, b);
    repeat (20) tick;
    checks++;
    if (ren_cyc.size() !== FIFO_DEPTH || pop_cyc.size() !== 0 || out_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_stall: rens=%0d pops=%0d valid=%0b required %0d 0 1", ren_cyc.size(), pop_cyc.size(), out_valid_o, FIFO_DEPTH);
    end
    out_ready_i = 1'b1; t1 = cyc;
    wait_done(1, 40);
    checks++;
    if (pop_data.size() !== N_TILES) begin failures++; $display("FAIL bp_popcount: got %0d required %0d", pop_data.size(), N_TILES); end
    for (int k = 0; k < N_TILES && k < pop_data.size(); k++) begin
      checks++;
      if (pop_data[k] !== tile_mul(a, hmem[AW'(b + AW'(k))]) || pop_tidx[k] !== TW'(k) ||
          pop_last[k] !== (k == N_TILES - 1) || pop_cyc[k] !== t1 + k) begin
        failures++;
        $display("FAIL bp_pop%0d: tidx=%0d cycle=%0d required tidx=%0d cycle=%0d (data lane0 %0h vs %0h)",
                 k, pop_tidx[k], pop_cyc[k] - t1, k, k, pop_data[k][15:0], fp16_mul(a, hmem[AW'(b + AW'(k))][15:0]));
      end
    end
    checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== t1 + N_TILES || stab_bad !== 0) begin
      failures++; $display("FAIL bp_done: dones=%0d unstable=%0d required 1 at pop+1 and 0", done_cyc.size(), stab_bad);
    end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] a;
    a = rand_fp16(13, 17);
    fill_random(8'hFC);
    out_ready_i = 1'b1;
    clear_mon;
    issue_start(a, 8'hFC);
    wait_done(1, 60);
    checks++;
    if (ren_addr.size() !== N_TILES || pop_data.size() !== N_TILES) begin
      failures++; $display("FAIL wrap_counts: rens=%0d pops=%0d required %0d", ren_addr.size(), pop_data.size(), N_TILES);
    end
    for (int k = 0; k < N_TILES && k < ren_addr.size() && k < pop_data.size(); k++) begin
      checks++;
      if (ren_addr[k] !== AW'((252 + k) % 256) || pop_data[k] !== tile_mul(a, hmem[(252 + k) % 256])) begin
        failures++; $display("FAIL wrap_%0d: addr=%0h required %0h", k, ren_addr[k], (252 + k) % 256);
      end
    end
  endtask

  task automatic test_random;
    logic [DW-1:0] a;
    logic [AW-1:0] b;
    int n;
    for (int it = 0; it < 4; it++) begin
      a = rand_fp16(13, 17); b = AW'($urandom);
      fill_random(b);
      clear_mon;
      issue_start(a, b);
      n = 0;
      while (done_cyc.size() == 0 && n < 400) begin out_ready_i = 1'($urandom % 2); tick; n++; end
      out_ready_i = 1'b1;
      checks++;
      if (pop_data.size() !== N_TILES || done_cyc.size() !== 1 || stab_bad !== 0 || ren_cyc.size() !== N_TILES) begin
        failures++;
        $display("FAIL rand%0d_counts: pops=%0d dones=%0d rens=%0d unstable=%0d required 8 1 8 0",
                 it, pop_data.size(), done_cyc.size(), ren_cyc.size(), stab_bad);
      end
      for (int k = 0; k < N_TILES && k < pop_data.size(); k++) begin
        checks++;
        if (pop_data[k] !== tile_mul(a, hmem[AW'(b + AW'(k))]) || pop_tidx[k] !== TW'(k) ||
            pop_last[k] !== (k == N_TILES - 1) || ren_addr[k] !== AW'(b + AW'(k))) begin
          failures++; $display("FAIL rand%0d_pop%0d: tidx=%0d addr=%0h required tidx=%0d addr=%0h",
                               it, k, pop_tidx[k], ren_addr[k], k, AW'(b + AW'(k)));
        end
      end
    end
  endtask

  task automatic test_sequencing;
    logic [DW-1:0] a1, a2, ea;
    logic [AW-1:0] eb;
    int n, t1;
    a1 = rand_fp16(13, 17); a2 = rand_fp16(13, 17);
    fill_random(8'h40); fill_random(8'h80);
    out_ready_i = 1'b1;
    clear_mon;
    issue_start(a1, 8'h40);
    tick; tick;
    start_i = 1'b1; base_i = 8'h99;
    tick;
    start_i = 1'b0;
    n = 0;
    while (done_o !== 1'b1 && n < 80) begin tick; n++; end
    checks++;
    if (done_o !== 1'b1) begin failures++; $display("FAIL seq_done1: done not seen within 80 cycles"); end
    t1 = cyc;
    issue_start(a2, 8'h80);
    wait_done(2, 60);
    checks++;
    if (ren_cyc.size() !== 2 * N_TILES || pop_data.size() !== 2 * N_TILES || done_cyc.size() !== 2) begin
      failures++; $display("FAIL seq_counts: rens=%0d pops=%0d dones=%0d required 16 16 2", ren_cyc.size(), pop_data.size(), done_cyc.size());
    end
    checks++;
    if (ren_cyc.size() > N_TILES && ren_cyc[N_TILES] !== t1 + 1) begin
      failures++; $display("FAIL seq_b2b: second first ren at +%0d required +1", ren_cyc[N_TILES] - t1);
    end
    for (int j = 0; j < 2 * N_TILES && j < ren_addr.size() && j < pop_data.size(); j++) begin
      ea = (j < N_TILES) ? a1 : a2;
      eb = (j < N_TILES) ? 8'h40 : 8'h80;
      checks++;
      if (ren_addr[j] !== AW'(eb + AW'(j % N_TILES)) || pop_tidx[j] !== TW'(j % N_TILES) ||
          pop_data[j] !== tile_mul(ea, hmem[AW'(eb + AW'(j % N_TILES))])) begin
        failures++; $display("FAIL seq_%0d: addr=%0h tidx=%0d required addr=%0h tidx=%0d",
                             j, ren_addr[j], pop_tidx[j], AW'(eb + AW'(j % N_TILES)), j % N_TILES);
      end
    end
    repeat (3) tick;
    inj = 1'b1;
    tick;
    inj = 1'b0;
    checks++;
    if (err_o !== 1'b1) begin failures++; $display("FAIL spurious_err: err=%0b required 1", err_o); end
    repeat (5) tick;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      failures++; $display("FAIL spurious_hold: err=%0b busy=%0b valid=%0b required 1 0 0", err_o, busy_o, out_valid_o);
    end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] a;
    logic [AW-1:0] b;
    int n;
    a = rand_fp16(13, 17); b = AW'($urandom);
    fill_random(b);
    out_ready_i = 1'b1;
    clear_mon;
    issue_start(a, b);
    n = 0;
    while (pop_data.size() < 3 && n < 60) begin tick; n++; end
    rstn = 1'b0;
    tick; tick;
    checks++;
    if (busy_o !== 1'b1 || out_valid_o !== 1'b0 || err_o !== 1'b0 || done_o !== 1'b0) begin
      failures++; $display("FAIL midrst_in_reset: busy=%0b valid=%0b err=%0b done=%0b required 1 0 0 0", busy_o, out_valid_o, err_o, done_o);
    end
    rstn = 1'b1;
    n = 0;
    while (busy_o && n < 20) begin tick; n++; end
    checks++;
    if (n !== 7 || err_o !== 1'b0 || done_cyc.size() !== 0 || pop_data.size() !== 3 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL midrst_flush: flush=%0d err=%0b dones=%0d pops=%0d valid=%0b required 7 0 0 3 0",
               n, err_o, done_cyc.size(), pop_data.size(), out_valid_o);
    end
    a = rand_fp16(13, 17); b = AW'($urandom);
    fill_random(b);
    clear_mon;
    issue_start(a, b);
    wait_done(1, 60);
    checks++;
    if (pop_data.size() !== N_TILES || done_cyc.size() !== 1 || err_o !== 1'b0) begin
      failures++; $display("FAIL midrst_new: pops=%0d dones=%0d err=%0b required 8 1 0", pop_data.size(), done_cyc.size(), err_o);
    end
    for (int k = 0; k < N_TILES && k < pop_data.size(); k++) begin
      checks++;
      if (pop_tidx[k] !== TW'(k) || pop_data[k] !== tile_mul(a, hmem[AW'(b + AW'(k))])) begin
        failures++; $display("FAIL midrst_pop%0d: tidx=%0d required %0d", k, pop_tidx[k], k);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_wrap;
    test_random;
    test_sequencing;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dah_tile_sched.md
# dah_tile_sched

Tile scheduler for the dA·h_prev multiplier array. On a start command it latches the scalar dA and a base address. It streams N_TILES consecutive h_prev tiles from the state buffer through the N_TILE-wide FP16 multiplier array, then returns the products in order on a valid/ready output. The multiplier pipeline cannot stall, so the block holds a credit-controlled result FIFO that absorbs downstream backpressure. It sits between the state-buffer read port and the dAh + dBx accumulation stage of the SSM update.

## Interface
- DW, 16: FP16 element width.
- N_TILE, 16: lanes per tile.
- N_TILES, 8: tiles per command. The state dimension is N_TILE*N_TILES.
- MUL_LAT, 6: multiplier array latency, valid in to valid out.
- RD_LAT, 1: state-buffer read latency, ren to rdata.
- FIFO_DEPTH, 8: result FIFO entries. Minimum 2.
- AW, 8: buffer address width.
- TW: derived, max(1, clog2(N_TILES)).

- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  command strobe, accepted only in IDLE
- dA_i  in  DW  scalar dA, latched on accept
- base_i  in  AW  first tile address, latched on accept
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on command completion
- err_o  out  1  sticky: unexpected mul_valid_i
- hbuf_ren_o  out  1  buffer read enable
- hbuf_raddr_o  out  AW  buffer read address
- hbuf_rdata_i  in  N_TILE*DW  tile data, RD_LAT cycles after ren
- mul_valid_o  out  1  drives the array's valid_i
- mul_dA_o  out  DW  latched dA
- mul_hprev_o  out  N_TILE*DW  hbuf_rdata_i passed through combinationally
- mul_valid_i  in  1  the array's valid_o
- mul_dAh_i  in  N_TILE*DW  the array's dAh_o
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  N_TILE*DW  product tile
- out_tidx_o  out  TW  tile index, 0..N_TILES-1
- out_last_o  out  1  high when out_tidx_o == N_TILES-1

## Operation
- **States:** FLUSH, IDLE, RUN, DRAIN.
- **FLUSH:**
  - Entered on reset.
  - Lasts RD_LAT+MUL_LAT cycles after rstn deasserts.
  - mul_valid_i is discarded and does not set err_o. start_i is ignored.
  - Then goes to IDLE.
- **IDLE → RUN:** on start_i. Latches dA_i and base_i, and clears issue_cnt and the write tile counter.
- **RUN:**
  - Issue condition: inflight + fifo_cnt − pop < FIFO_DEPTH, where pop = out_valid_o & out_ready_i in the same cycle.
  - When the condition holds, assert hbuf_ren_o with hbuf_raddr_o = base + issue_cnt (mod 2^AW), and increment issue_cnt.
  - After issuing tile N_TILES−1, go to DRAIN.
- **Read-enable pipeline:** hbuf_ren_o is delayed RD_LAT cycles to form mul_valid_o.
- **In-flight counter:** inflight increments on ren and decrements on mul_valid_i. Both in the same cycle leaves it unchanged.
- **Result capture:**
  - mul_valid_i while inflight > 0 writes {mul_dAh_i, write tile counter} into the FIFO and increments the counter.
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
- **Unexpected results:** mul_valid_i with inflight == 0 outside FLUSH is discarded and sets err_o. err_o clears only on reset.
- **Output:** out_valid_o = FIFO non-empty. Results leave in issue order. Pop occurs on valid & ready.
- **DRAIN → IDLE:** on the pop of the last tile. done_o pulses high the following cycle, with busy_o already low.
- **Back-to-back commands:** start_i in the done_o cycle is accepted.
- **Reset values:**
  - All outputs are 0.
  - State is FLUSH, so busy_o = 1.
  - FIFO is empty and all counters are 0.
- **Reset mid-command:** all state is discarded and no done_o is produced. Stale products arriving during FLUSH are dropped.

## Timing
- Command latency with start_i sampled at cycle 0 and out_ready_i held high:
  - cycle 1: first ren.
  - cycle 1+RD_LAT: first mul_valid_o.
  - cycle 1+RD_LAT+MUL_LAT: first mul_valid_i.
  - cycle 2+RD_LAT+MUL_LAT: first out_valid_o, which is cycle 9 at defaults.
- **Throughput:** one tile per cycle when FIFO_DEPTH ≥ RD_LAT+MUL_LAT+1 and ready stays high.
  - Defaults: last pop at cycle 16, done_o at cycle 17.
- **Backpressure:** with ready held low, at most FIFO_DEPTH tiles are issued. Issue resumes the cycle ready returns, because the credit check includes the same-cycle pop.
- **Handshake:** out_data_o, out_tidx_o and out_last_o stay stable while out_valid_o=1 and out_ready_i=0.

## Test plan
- **Reset:** release reset. busy_o=1 for 7 cycles then 0, all outputs 0. Inject mul_valid_i during FLUSH → dropped, err_o stays 0.
- **Single command:** dA=0x4000 (2.0), base=0x10, h tiles of 0x3C00, ready=1.
  - ren at addresses 0x10..0x17 on cycles 1–8.
  - Every output lane is 0x4000, tidx 0..7, last on tidx 7.
  - done_o at cycle 17.
- **Backpressure:** ready=0 for 20 cycles after start.
  - Exactly 8 ren pulses, no overflow.
  - On ready=1: 8 back-to-back pops, then done_o.
- **Address wrap:** base=0xFC → addresses 0xFC, 0xFD, 0xFE, 0xFF, 0x00, 0x01, 0x02, 0x03.
- **Sequencing:**
  - start_i while busy → ignored.
  - start_i in the done_o cycle → accepted, next ren one cycle later.
  - Spurious mul_valid_i in IDLE → err_o=1 and held.
- **Reset mid-command:** assert rstn after the 3rd pop.
  - No done_o, FIFO empty.
  - Late products during FLUSH are dropped.
  - A new command then completes with correct tidx 0..7.
